// File: rtl/i2s_speaker_ctrl.sv
// i2s_speaker_ctrl: volume-scaled stereo sample capture and I2S serializer for the Pmod I2S DAC
module i2s_speaker_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    input  logic [2:0]  volume,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        sample_tick
);
    logic [8:0]  cnt;
    logic [8:0]  cnt_n;
    logic [2:0]  vol;
    logic [15:0] left_scaled;
    logic [15:0] right_scaled;
    logic [15:0] left_hold;
    logic [15:0] right_stage;
    logic [15:0] right_hold;
    logic [4:0]  slot;
    logic        bit_next;

    assign cnt_n = cnt + 9'd1;

    // Attenuation by arithmetic shift, and selection of the bit for the slot about to start
    always_comb begin
        vol          = volume > 3'd5 ? 3'd5 : volume;
        left_scaled  = vol == 3'd0 ? 16'h0000 : 16'($signed(audio_left) >>> (3'd5 - vol));
        right_scaled = vol == 3'd0 ? 16'h0000 : 16'($signed(audio_right) >>> (3'd5 - vol));
        slot         = cnt_n[8:4] - 5'd1;
        bit_next     = slot[4] ? right_hold[~slot[3:0]] : left_hold[~slot[3:0]];
    end

    // Free-running frame counter; clock outputs track the counter value they accompany
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            audio_mclk  <= 1'b0;
            audio_sck   <= 1'b0;
            audio_lrck  <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            audio_mclk  <= cnt_n[1];
            audio_sck   <= cnt_n[3];
            audio_lrck  <= cnt_n[8];
            sample_tick <= &cnt_n;
        end
    end

    // Frame capture, mid-frame right-word handoff and serial data on SCK falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_hold   <= '0;
            right_stage <= '0;
            right_hold  <= '0;
            audio_sdin  <= 1'b0;
        end else begin
            if (&cnt) begin
                left_hold   <= left_scaled;
                right_stage <= right_scaled;
            end
            if (cnt == 9'd255)
                right_hold <= right_stage;
            if (cnt_n[3:0] == 4'd0)
                audio_sdin <= bit_next;
        end
    end
endmodule

// File: tb/tb_i2s_speaker_ctrl.sv
// tb_i2s_speaker_ctrl: scoreboard bench for the I2S speaker controller
module tb_i2s_speaker_ctrl;
    logic        clk;
    logic        rst;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic [2:0]  volume;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        sample_tick;

    int          total;
    int          bad;
    logic [8:0]  tb_cnt;
    logic [31:0] exp_q[$];

    i2s_speaker_ctrl dut (
        .clk(clk),
        .rst(rst),
        .audio_left(audio_left),
        .audio_right(audio_right),
        .volume(volume),
        .audio_mclk(audio_mclk),
        .audio_lrck(audio_lrck),
        .audio_sck(audio_sck),
        .audio_sdin(audio_sdin),
        .sample_tick(sample_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference frame position, counted from reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tb_cnt <= '0;
        else
            tb_cnt <= tb_cnt + 9'd1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [15:0] atten(input logic [15:0] x, input logic [2:0] vol);
        int v;
        int val;
        v = vol > 3'd5 ? 5 : int'(vol);
        if (v == 0)
            return 16'h0000;
        val = int'($signed(x));
        val = val >>> (5 - v);
        return val[15:0];
    endfunction

    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(tb_cnt) != c && n < 1100);
        if (int'(tb_cnt) != c) begin
            total++;
            bad++;
            $display("FAIL wait_cnt: got cnt=%0d, required %0d", tb_cnt, c);
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [2:0] v);
        wait_cnt(511);
        audio_left  = l;
        audio_right = r;
        volume      = v;
        exp_q.push_back({atten(l, v), atten(r, v)});
    endtask

    task automatic collect(output logic [15:0] l, output logic [15:0] r);
        int s;
        l = '0;
        r = '0;
        for (int k = 1; k < 32; k++) begin
            wait_cnt(k * 16 + 8);
            s = k - 1;
            if (s < 16)
                l[15 - s] = audio_sdin;
            else
                r[31 - s] = audio_sdin;
        end
        wait_cnt(8);
        r[0] = audio_sdin;
    endtask

    task automatic test_reset();
        logic [15:0] l, r;
        total++;
        if ({audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick});
        end
        rst = 1'b0;
        collect(l, r);
        total++;
        if ({l, r} !== 32'h0) begin
            bad++;
            $display("FAIL first_frame: got %h_%h, required 0000_0000", l, r);
        end
        exp_q.delete();
        send(16'hFFFF, 16'hFFFF, 3'd5);
        wait_cnt(40);
        total++;
        if (audio_sdin !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_sdin: got %b, required 1", audio_sdin);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick} !== 5'b0) begin
            bad++;
            $display("FAIL midframe_reset: got %b, required 00000",
                     {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick});
        end
        @(negedge clk);
        rst = 1'b0;
        collect(l, r);
        total++;
        if ({l, r} !== 32'h0) begin
            bad++;
            $display("FAIL after_reset_frame: got %h_%h, required 0000_0000", l, r);
        end
        exp_q.delete();
    endtask

    task automatic test_clocks();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            total++;
            if ({audio_mclk, audio_sck, audio_lrck, sample_tick} !==
                {tb_cnt[1], tb_cnt[3], tb_cnt[8], tb_cnt == 9'd511}) begin
                bad++;
                $display("FAIL clocks at cnt=%0d: got mclk/sck/lrck/tick=%b, required %b", tb_cnt,
                         {audio_mclk, audio_sck, audio_lrck, sample_tick},
                         {tb_cnt[1], tb_cnt[3], tb_cnt[8], tb_cnt == 9'd511});
            end
        end
    endtask

    task automatic test_serial();
        logic [15:0] l, r;
        logic [31:0] e;
        exp_q.delete();
        send(16'hA000, 16'h6000, 3'd5);
        collect(l, r);
        e = exp_q.pop_front();
        total++;
        if ({l, r} !== e) begin
            bad++;
            $display("FAIL serial_sb: got %h_%h, required %h_%h", l, r, e[31:16], e[15:0]);
        end
        total++;
        if ({l, r} !== 32'hA000_6000) begin
            bad++;
            $display("FAIL serial_words: got %h_%h, required a000_6000", l, r);
        end
    endtask

    task automatic test_atten();
        logic [15:0] l, r;
        logic [31:0] e;
        logic [15:0] want [3] = '{16'hE800, 16'h0000, 16'hA000};
        logic [2:0]  vols [3] = '{3'd3, 3'd0, 3'd7};
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(16'hA000, 16'h7FFF, vols[i]);
            collect(l, r);
            e = exp_q.pop_front();
            total++;
            if (l !== want[i]) begin
                bad++;
                $display("FAIL atten_left vol=%0d: got %h, required %h", vols[i], l, want[i]);
            end
            total++;
            if (r !== e[15:0]) begin
                bad++;
                $display("FAIL atten_right vol=%0d: got %h, required %h", vols[i], r, e[15:0]);
            end
        end
    endtask

    task automatic test_isolation();
        logic [15:0] l, r;
        logic [31:0] e;
        exp_q.delete();
        send(16'h1234, 16'h00F0, 3'd5);
        fork
            begin
                repeat (101) @(negedge clk);
                audio_left = 16'hFFFF;
            end
        join_none
        exp_q.push_back({16'hFFFF, 16'h00F0});
        for (int i = 0; i < 2; i++) begin
            collect(l, r);
            e = exp_q.pop_front();
            total++;
            if ({l, r} !== e) begin
                bad++;
                $display("FAIL isolation frame%0d: got %h_%h, required %h_%h", i, l, r, e[31:16], e[15:0]);
            end
        end
    endtask

    task automatic test_one_bit_delay();
        exp_q.delete();
        send(16'h0000, 16'h0001, 3'd5);
        wait_cnt(511);
        audio_left  = 16'h8000;
        audio_right = 16'h0000;
        wait_cnt(8);
        total++;
        if ({audio_sdin, audio_lrck} !== 2'b10) begin
            bad++;
            $display("FAIL slot0: got sdin/lrck=%b, required 10", {audio_sdin, audio_lrck});
        end
        wait_cnt(24);
        total++;
        if ({audio_sdin, audio_lrck} !== 2'b10) begin
            bad++;
            $display("FAIL slot1_msb: got sdin/lrck=%b, required 10", {audio_sdin, audio_lrck});
        end
        wait_cnt(40);
        total++;
        if (audio_sdin !== 1'b0) begin
            bad++;
            $display("FAIL slot2: got %b, required 0", audio_sdin);
        end
    endtask

    task automatic test_random();
        logic [15:0] l, r;
        logic [31:0] e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
            collect(l, r);
            e = exp_q.pop_front();
            total++;
            if ({l, r} !== e) begin
                bad++;
                $display("FAIL random%0d vol=%0d: got %h_%h, required %h_%h", i, volume, l, r, e[31:16], e[15:0]);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        audio_left  = '0;
        audio_right = '0;
        volume      = 3'd5;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_clocks();
        test_serial();
        test_atten();
        test_isolation();
        test_one_bit_delay();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
